branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
ID-stage controller that sequences the branch comparator (Aluc/in_a/in_b → Zero/Sign) for the pipelined MIPS core.
- Selects the comparator opcode and the operand forwarding sources.
- Inserts stall cycles when a branch source register is still being produced.
- Evaluates the branch condition from Zero/Sign and drives PC redirect and IF flush.
- Sits between the hazard unit inputs (EX/MEM pipeline registers) and the IF/ID control.

Parameters:
- STALL_W, 2, width of the stall down-counter (max stall 2 cycles).
- CNT_W, 32, width of the statistics counters (optional feature only).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- br_valid  input  1  ID holds a branch instruction; held stable by the pipeline while stall=1.
- br_type  input  3  0=BEQ 1=BNE 2=BGEZ 3=BGTZ 4=BLEZ 5=BLTZ; 6,7 illegal.
- rs_addr  input  5  branch source A.
- rt_addr  input  5  branch source B (used by BEQ/BNE only).
- ex_wreg, ex_mem2reg  input  1 each  EX-stage instruction writes a register / is a load.
- ex_waddr  input  5  EX destination register.
- mem_wreg, mem_mem2reg  input  1 each  MEM-stage write / load.
- mem_waddr  input  5  MEM destination register.
- zero, sign  input  1 each  comparator flags.
- aluc  output  4  comparator opcode: `ALUSub for types 0,1; `ALUSubZero for types 2-5; `ALUSub when idle.
- fwd_a, fwd_b  output  2 each  0=regfile, 1=MEM ALU result, 2=WB result.
- stall  output  1  freeze PC and IF/ID; bubble into ID/EX.
- pc_src  output  1  take branch target this cycle.
- flush_if  output  1  squash the IF/ID instruction.
- stat_br, stat_taken, stat_stall  output  CNT_W each  statistics counters.

Behaviour:
- Reset (async) values: state=IDLE, cnt=0, all statistics counters=0. With rst=1, outputs are stall=0, pc_src=0, flush_if=0, fwd=0.
- Dependency on a register: the address is nonzero and equals rs_addr, or equals rt_addr for types 0/1 only.
- need (evaluated in IDLE with br_valid=1):
  - 2 if an EX load writes a dependent register.
  - Otherwise 1 if an EX non-load write, or a MEM load, targets a dependent register.
  - Otherwise 0.
- FSM IDLE:
  - br_valid=0: all control outputs 0.
  - br_valid=1 and need=0: resolve this cycle, stall=0.
  - br_valid=1 and need>0: stall=1, cnt<=need-1, go to STALL if need=2, else RESOLVE.
- FSM STALL: stall=1, hazard inputs ignored, go to RESOLVE.
- FSM RESOLVE: stall=0, resolve, go to IDLE.
- Total stall cycles equal need exactly; the branch resolves in cycle N+need.
- br_valid=0 in STALL or RESOLVE (external flush): abort, stall=0 in that cycle, go to IDLE, no resolve, no counting.
- Resolve cycle:
  - Forwarding: fwd_x=1 if a non-load MEM write matches the source; else 2 if the WB-stage producer matches (mem stage of the previous cycle, tracked by a registered copy of mem_waddr/mem_wreg); else 0. Register 0 is never forwarded.
  - Taken: BEQ=zero; BNE=!zero; BGEZ=!sign; BGTZ=!sign&!zero; BLEZ=sign|zero; BLTZ=sign; types 6,7 never taken.
  - pc_src=taken, flush_if=taken. Both are combinational, valid only in the resolve cycle.
- Back-to-back branches: a new br_valid in the cycle after a resolve starts a fresh IDLE evaluation.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined: stat_br increments per resolved branch, stat_taken per taken branch, stat_stall per cycle with stall=1. All wrap modulo 2^CNT_W; aborts are not counted as branches.
- Undefined: the counters are not built and the stat_* outputs are constant 0.

Decomposition:
- Shared define file holds `ALUSub, `ALUSubZero and new `BR_BEQ..`BR_BLTZ type codes plus fwd select codes.
- One sub-module, branch_cond_eval: combinational br_type/zero/sign → taken and aluc. The FSM, counter and forwarding logic stay in the top module.

Test Plan:
- BEQ, no hazards, zero=1 → same cycle pc_src=1, flush_if=1, stall=0, aluc=`ALUSub.
- BNE rs=5, EX load ex_waddr=5 → stall=1 for exactly 2 cycles; resolve in 3rd cycle with zero=0 → pc_src=1.
- BGTZ rs=8, EX ALU writes r8 → 1 stall cycle; resolve with fwd_a=1; sign=0, zero=1 → pc_src=0.
- BLTZ with rt_addr=9 and EX load writing r9 → need=0 (rt unused), no stall; sign=1 → taken. ex_waddr=0 write → never stalls.
- Async rst asserted mid-STALL → stall drops immediately; after release, state is IDLE and stat_* = 0. br_valid dropped in STALL → abort, no pc_src.
- With BRANCH_STATS_EN: 3 branches, 2 taken, 3 stall cycles → stat_br=3, stat_taken=2, stat_stall=3.

Source files
------------

// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared type codes, comparator opcodes and forwarding selects for the branch resolve controller.
// The `ALUSub/`ALUSubZero/`BR_*/`FWD_* macros mirror the core's define set; RTL uses the localparams.
`ifndef BRANCH_RESOLVE_CTRL_DEFS
`define BRANCH_RESOLVE_CTRL_DEFS
`define ALUSub     4'b0110
`define ALUSubZero 4'b0111
`define BR_BEQ     3'd0
`define BR_BNE     3'd1
`define BR_BGEZ    3'd2
`define BR_BGTZ    3'd3
`define BR_BLEZ    3'd4
`define BR_BLTZ    3'd5
`define FWD_RF     2'd0
`define FWD_MEM    2'd1
`define FWD_WB     2'd2
`endif

package branch_resolve_ctrl_pkg;

  localparam logic [3:0] ALU_SUB      = `ALUSub;
  localparam logic [3:0] ALU_SUB_ZERO = `ALUSubZero;

  localparam logic [2:0] BR_BEQ  = `BR_BEQ;
  localparam logic [2:0] BR_BNE  = `BR_BNE;
  localparam logic [2:0] BR_BGEZ = `BR_BGEZ;
  localparam logic [2:0] BR_BGTZ = `BR_BGTZ;
  localparam logic [2:0] BR_BLEZ = `BR_BLEZ;
  localparam logic [2:0] BR_BLTZ = `BR_BLTZ;

  localparam logic [1:0] FWD_RF  = `FWD_RF;
  localparam logic [1:0] FWD_MEM = `FWD_MEM;
  localparam logic [1:0] FWD_WB  = `FWD_WB;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STALL   = 2'd1,
    ST_RESOLVE = 2'd2
  } state_e;

  // Only the two-register compares read rt; the sign tests compare rs against zero.
  function automatic logic uses_rt(input logic [2:0] br_type);
    return (br_type == BR_BEQ) || (br_type == BR_BNE);
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_cond.sv
// branch_cond_eval: maps branch type and comparator flags to the taken decision and comparator opcode.
module branch_cond_eval
  import branch_resolve_ctrl_pkg::*;
(
  input  logic [2:0] br_type,
  input  logic       zero,
  input  logic       sign,
  output logic       taken,
  output logic [3:0] aluc
);

  always_comb begin
    taken = 1'b0;
    aluc  = ALU_SUB;
    case (br_type)
      BR_BEQ:  taken = zero;
      BR_BNE:  taken = !zero;
      BR_BGEZ: begin taken = !sign;          aluc = ALU_SUB_ZERO; end
      BR_BGTZ: begin taken = !sign && !zero; aluc = ALU_SUB_ZERO; end
      BR_BLEZ: begin taken = sign || zero;   aluc = ALU_SUB_ZERO; end
      BR_BLTZ: begin taken = sign;           aluc = ALU_SUB_ZERO; end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch controller: hazard stalls, operand forwarding select and PC redirect/IF flush.
// Optional statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int STALL_W = 2,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  input  logic [2:0]       br_type,
  input  logic [4:0]       rs_addr,
  input  logic [4:0]       rt_addr,
  input  logic             ex_wreg,
  input  logic             ex_mem2reg,
  input  logic [4:0]       ex_waddr,
  input  logic             mem_wreg,
  input  logic             mem_mem2reg,
  input  logic [4:0]       mem_waddr,
  input  logic             zero,
  input  logic             sign,
  output logic [3:0]       aluc,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall,
  output logic             pc_src,
  output logic             flush_if,
  output logic [CNT_W-1:0] stat_br,
  output logic [CNT_W-1:0] stat_taken,
  output logic [CNT_W-1:0] stat_stall
);

  state_e             state_q, state_d;
  logic [STALL_W-1:0] cnt_q, cnt_d;
  logic               wb_wreg_q, wb_wreg_d;
  logic [4:0]         wb_waddr_q, wb_waddr_d;

  logic       rt_used, ex_dep, mem_dep;
  logic [1:0] need;
  logic       stall_c, resolve, taken;
  logic [3:0] cond_aluc;
  logic       mem_fwd_ok, wb_fwd_ok;
  logic [1:0] sel_a, sel_b;

  branch_cond_eval u_cond (
    .br_type (br_type),
    .zero    (zero),
    .sign    (sign),
    .taken   (taken),
    .aluc    (cond_aluc)
  );

  assign rt_used = uses_rt(br_type);
  assign ex_dep  = ex_wreg && (ex_waddr != 5'd0) &&
                   ((ex_waddr == rs_addr) || (rt_used && (ex_waddr == rt_addr)));
  assign mem_dep = mem_wreg && (mem_waddr != 5'd0) &&
                   ((mem_waddr == rs_addr) || (rt_used && (mem_waddr == rt_addr)));

  // An EX load needs two cycles to reach WB; an EX ALU result or a MEM load needs one.
  always_comb begin
    need = 2'd0;
    if (ex_dep && ex_mem2reg)
      need = 2'd2;
    else if (ex_dep || (mem_dep && mem_mem2reg))
      need = 2'd1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    resolve = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (br_valid) begin
          if (need == 2'd0) begin
            resolve = 1'b1;
          end else begin
            stall_c = 1'b1;
            cnt_d   = STALL_W'(need - 2'd1);
            state_d = (need == 2'd2) ? ST_STALL : ST_RESOLVE;
          end
        end
      end
      ST_STALL: begin
        if (!br_valid) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - STALL_W'(1);
          if (cnt_q <= STALL_W'(1))
            state_d = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        resolve = br_valid;
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // WB-stage producer is simply last cycle's MEM-stage write.
  assign wb_wreg_d  = mem_wreg;
  assign wb_waddr_d = mem_waddr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wb_wreg_q  <= 1'b0;
      wb_waddr_q <= 5'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_wreg_q  <= wb_wreg_d;
      wb_waddr_q <= wb_waddr_d;
    end
  end

  assign mem_fwd_ok = mem_wreg && !mem_mem2reg && (mem_waddr != 5'd0);
  assign wb_fwd_ok  = wb_wreg_q && (wb_waddr_q != 5'd0);

  always_comb begin
    sel_a = FWD_RF;
    if (mem_fwd_ok && (mem_waddr == rs_addr))
      sel_a = FWD_MEM;
    else if (wb_fwd_ok && (wb_waddr_q == rs_addr))
      sel_a = FWD_WB;
    sel_b = FWD_RF;
    if (rt_used) begin
      if (mem_fwd_ok && (mem_waddr == rt_addr))
        sel_b = FWD_MEM;
      else if (wb_fwd_ok && (wb_waddr_q == rt_addr))
        sel_b = FWD_WB;
    end
  end

  // Reset gates the outputs directly so a mid-stall reset releases the pipeline at once.
  assign stall    = stall_c && !rst;
  assign pc_src   = resolve && taken && !rst;
  assign flush_if = resolve && taken && !rst;
  assign fwd_a    = (resolve && !rst) ? sel_a : FWD_RF;
  assign fwd_b    = (resolve && !rst) ? sel_b : FWD_RF;
  assign aluc     = (br_valid && !rst) ? cond_aluc : ALU_SUB;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] stat_br_q, stat_br_d;
  logic [CNT_W-1:0] stat_taken_q, stat_taken_d;
  logic [CNT_W-1:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_br_d    = stat_br_q + CNT_W'(resolve);
    stat_taken_d = stat_taken_q + CNT_W'(resolve && taken);
    stat_stall_d = stat_stall_q + CNT_W'(stall_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_br_q    <= '0;
      stat_taken_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_br_q    <= stat_br_d;
      stat_taken_q <= stat_taken_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_br    = stat_br_q;
  assign stat_taken = stat_taken_q;
  assign stat_stall = stat_stall_q;
`else
  assign stat_br    = '0;
  assign stat_taken = '0;
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: single-cycle vector table plus hand-written stall/abort/reset sequences.
module tb_branch_resolve_ctrl;
  import branch_resolve_ctrl_pkg::*;

  typedef struct packed {
    logic       br_valid;
    logic [2:0] br_type;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ex_wreg;
    logic       ex_m2r;
    logic [4:0] ex_waddr;
    logic       mem_wreg;
    logic       mem_m2r;
    logic [4:0] mem_waddr;
    logic       zero;
    logic       sign;
  } in_t;

  typedef struct packed {
    logic       stall;
    logic       pc_src;
    logic       flush_if;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic [3:0] aluc;
    logic       chk_aluc;
  } exp_t;

  typedef struct packed {
    in_t        in;
    logic       wb_wreg;
    logic [4:0] wb_waddr;
    exp_t       exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid, ex_wreg, ex_mem2reg, mem_wreg, mem_mem2reg, zero, sign;
  logic [2:0]  br_type;
  logic [4:0]  rs_addr, rt_addr, ex_waddr, mem_waddr;
  logic [3:0]  aluc;
  logic [1:0]  fwd_a, fwd_b;
  logic        stall, pc_src, flush_if;
  logic [31:0] stat_br, stat_taken, stat_stall;

  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t exp_q[$];
  vec_t vecs[16];

  branch_resolve_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .br_valid    (br_valid),
    .br_type     (br_type),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .ex_wreg     (ex_wreg),
    .ex_mem2reg  (ex_mem2reg),
    .ex_waddr    (ex_waddr),
    .mem_wreg    (mem_wreg),
    .mem_mem2reg (mem_mem2reg),
    .mem_waddr   (mem_waddr),
    .zero        (zero),
    .sign        (sign),
    .aluc        (aluc),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall       (stall),
    .pc_src      (pc_src),
    .flush_if    (flush_if),
    .stat_br     (stat_br),
    .stat_taken  (stat_taken),
    .stat_stall  (stat_stall)
  );

  always #5 clk = ~clk;

  function automatic in_t mk_in(input logic v, input logic [2:0] t, input logic [4:0] rs, input logic [4:0] rt,
                                input logic exw, input logic exl, input logic [4:0] exa,
                                input logic mw, input logic ml, input logic [4:0] ma,
                                input logic z, input logic s);
    in_t i;
    i = '{br_valid: v, br_type: t, rs: rs, rt: rt, ex_wreg: exw, ex_m2r: exl, ex_waddr: exa,
          mem_wreg: mw, mem_m2r: ml, mem_waddr: ma, zero: z, sign: s};
    return i;
  endfunction

  function automatic exp_t mk_exp(input logic st, input logic pc, input logic [1:0] fa,
                                  input logic [1:0] fb, input logic [3:0] al);
    exp_t e;
    e = '{stall: st, pc_src: pc, flush_if: pc, fwd_a: fa, fwd_b: fb, aluc: al, chk_aluc: 1'b1};
    return e;
  endfunction

  function automatic exp_t mk_stall();
    exp_t e;
    e = mk_exp(1'b1, 1'b0, FWD_RF, FWD_RF, ALU_SUB);
    e.chk_aluc = 1'b0;
    return e;
  endfunction

  function automatic vec_t mk_vec(input in_t i, input logic ww, input logic [4:0] wa, input exp_t e);
    vec_t v;
    v = '{in: i, wb_wreg: ww, wb_waddr: wa, exp: e};
    return v;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic drive(input in_t i);
    br_valid    = i.br_valid;
    br_type     = i.br_type;
    rs_addr     = i.rs;
    rt_addr     = i.rt;
    ex_wreg     = i.ex_wreg;
    ex_mem2reg  = i.ex_m2r;
    ex_waddr    = i.ex_waddr;
    mem_wreg    = i.mem_wreg;
    mem_mem2reg = i.mem_m2r;
    mem_waddr   = i.mem_waddr;
    zero        = i.zero;
    sign        = i.sign;
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val({name, " scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_val({name, " stall"},    32'(stall),    32'(e.stall));
      check_val({name, " pc_src"},   32'(pc_src),   32'(e.pc_src));
      check_val({name, " flush_if"}, 32'(flush_if), 32'(e.flush_if));
      check_val({name, " fwd_a"},    32'(fwd_a),    32'(e.fwd_a));
      check_val({name, " fwd_b"},    32'(fwd_b),    32'(e.fwd_b));
      if (e.chk_aluc)
        check_val({name, " aluc"}, 32'(aluc), 32'(e.aluc));
    end
  endtask

  // One pipeline cycle: drive just after the edge, compare on the falling edge.
  task automatic applyStimulus(input in_t i, input exp_t e, input string name);
    @(posedge clk);
    #1;
    drive(i);
    exp_q.push_back(e);
    @(negedge clk);
    checkOutput(name);
  endtask

  task automatic check_stats(input string name, input logic [31:0] br, input logic [31:0] tk, input logic [31:0] st);
`ifdef BRANCH_STATS_EN
    check_val({name, " stat_br"},    stat_br,    br);
    check_val({name, " stat_taken"}, stat_taken, tk);
    check_val({name, " stat_stall"}, stat_stall, st);
`else
    check_val({name, " stat_br"},    stat_br,    32'd0 & br);
    check_val({name, " stat_taken"}, stat_taken, 32'd0 & tk);
    check_val({name, " stat_stall"}, stat_stall, 32'd0 & st);
`endif
  endtask

  in_t  idle_in;
  exp_t idle_exp;

  initial begin
    idle_in  = mk_in(1'b0, BR_BEQ, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    idle_exp = mk_exp(1'b0, 1'b0, FWD_RF, FWD_RF, ALU_SUB);

    // in: valid type rs rt | exw exl exa | mw ml ma | zero sign ; then wb, expected
    vecs[0]  = mk_vec(mk_in(1, BR_BEQ,  1,  2, 0,0,0,  0,0,0,  1,0), 0, 0,  mk_exp(0,1,FWD_RF, FWD_RF, ALU_SUB));
    vecs[1]  = mk_vec(mk_in(1, BR_BEQ,  1,  2, 0,0,0,  0,0,0,  0,0), 0, 0,  mk_exp(0,0,FWD_RF, FWD_RF, ALU_SUB));
    vecs[2]  = mk_vec(mk_in(1, BR_BNE,  3,  4, 0,0,0,  0,0,0,  0,0), 0, 0,  mk_exp(0,1,FWD_RF, FWD_RF, ALU_SUB));
    vecs[3]  = mk_vec(mk_in(1, BR_BGEZ, 3,  0, 0,0,0,  0,0,0,  0,0), 0, 0,  mk_exp(0,1,FWD_RF, FWD_RF, ALU_SUB_ZERO));
    vecs[4]  = mk_vec(mk_in(1, BR_BGTZ, 3,  0, 0,0,0,  0,0,0,  1,0), 0, 0,  mk_exp(0,0,FWD_RF, FWD_RF, ALU_SUB_ZERO));
    vecs[5]  = mk_vec(mk_in(1, BR_BLEZ, 3,  0, 0,0,0,  0,0,0,  1,0), 0, 0,  mk_exp(0,1,FWD_RF, FWD_RF, ALU_SUB_ZERO));
    vecs[6]  = mk_vec(mk_in(1, BR_BLTZ, 3,  9, 1,1,9,  0,0,0,  0,1), 0, 0,  mk_exp(0,1,FWD_RF, FWD_RF, ALU_SUB_ZERO));
    vecs[7]  = mk_vec(mk_in(1, BR_BEQ,  0,  0, 1,1,0,  0,0,0,  1,0), 0, 0,  mk_exp(0,1,FWD_RF, FWD_RF, ALU_SUB));
    vecs[8]  = mk_vec(mk_in(1, 3'd6,    1,  2, 0,0,0,  0,0,0,  1,1), 0, 0,  mk_exp(0,0,FWD_RF, FWD_RF, ALU_SUB));
    vecs[9]  = mk_vec(mk_in(1, BR_BEQ,  6,  7, 0,0,0,  1,0,6,  0,0), 1, 7,  mk_exp(0,0,FWD_MEM,FWD_WB, ALU_SUB));
    vecs[10] = mk_vec(mk_in(1, BR_BNE, 10, 11, 0,0,0,  1,0,10, 1,0), 1, 10, mk_exp(0,0,FWD_MEM,FWD_RF, ALU_SUB));
    vecs[11] = mk_vec(mk_in(0, BR_BEQ,  1,  2, 0,0,0,  0,0,0,  1,0), 0, 0,  mk_exp(0,0,FWD_RF, FWD_RF, ALU_SUB));
    vecs[12] = mk_vec(mk_in(1, BR_BLTZ,12,  0, 0,0,0,  0,0,0,  0,0), 1, 12, mk_exp(0,0,FWD_WB, FWD_RF, ALU_SUB_ZERO));
    vecs[13] = mk_vec(mk_in(1, BR_BEQ, 13, 14, 0,0,13, 1,1,15, 1,0), 1, 14, mk_exp(0,1,FWD_RF, FWD_WB, ALU_SUB));
    vecs[14] = mk_vec(mk_in(1, 3'd7,    1,  2, 0,0,0,  0,0,0,  0,0), 0, 0,  mk_exp(0,0,FWD_RF, FWD_RF, ALU_SUB));
    vecs[15] = mk_vec(mk_in(1, BR_BLEZ, 3,  0, 0,0,0,  0,0,0,  0,1), 0, 0,  mk_exp(0,1,FWD_RF, FWD_RF, ALU_SUB_ZERO));

    // Reset: outputs must be quiet even with a resolvable branch presented.
    rst = 1'b1;
    drive(mk_in(1, BR_BEQ, 1, 2, 0,0,0, 0,0,0, 1,0));
    #3;
    exp_q.push_back(idle_exp);
    checkOutput("reset");
    check_stats("reset", 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 16; k++) begin
      in_t pre;
      pre = idle_in;
      pre.mem_wreg  = vecs[k].wb_wreg;
      pre.mem_waddr = vecs[k].wb_waddr;
      applyStimulus(pre, idle_exp, $sformatf("vec%0d_pre", k));
      applyStimulus(vecs[k].in, vecs[k].exp, $sformatf("vec%0d", k));
    end

    // MEM load on rt of BEQ: one stall, then the load result comes from WB.
    applyStimulus(mk_in(1, BR_BEQ, 20, 21, 0,0,0, 1,1,21, 1,0), mk_stall(), "memload_stall");
    applyStimulus(mk_in(1, BR_BEQ, 20, 21, 0,0,0, 0,0,0,  1,0), mk_exp(0,1,FWD_RF,FWD_WB,ALU_SUB), "memload_resolve");

    // Abort: br_valid drops while in STALL.
    applyStimulus(mk_in(1, BR_BNE, 5, 6, 1,1,5, 0,0,0, 0,0), mk_stall(), "abort_stall");
    applyStimulus(mk_in(0, BR_BNE, 5, 6, 0,0,0, 1,1,5, 0,0), idle_exp, "abort_drop");
    applyStimulus(mk_in(1, BR_BEQ, 1, 2, 0,0,0, 0,0,0, 1,0), mk_exp(0,1,FWD_RF,FWD_RF,ALU_SUB), "abort_next");

    // Async reset in the middle of a load stall.
    applyStimulus(mk_in(1, BR_BNE, 5, 6, 1,1,5, 0,0,0, 0,0), mk_stall(), "rstmid_stall1");
    applyStimulus(mk_in(1, BR_BNE, 5, 6, 0,0,0, 1,1,5, 0,0), mk_stall(), "rstmid_stall2");
    #2;
    rst = 1'b1;
    #1;
    exp_q.push_back(idle_exp);
    checkOutput("rstmid_asserted");
    check_stats("rstmid", 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(idle_in);
    applyStimulus(mk_in(1, BR_BEQ, 1, 2, 0,0,0, 0,0,0, 1,0), mk_exp(0,1,FWD_RF,FWD_RF,ALU_SUB), "rstmid_after");

    // Statistics run from a clean reset: 3 branches, 2 taken, 3 stall cycles.
    @(negedge clk);
    rst = 1'b1;
    drive(idle_in);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(mk_in(1, BR_BNE, 5, 6, 1,1,5, 0,0,0, 0,0), mk_stall(), "bne_load_s1");
    applyStimulus(mk_in(1, BR_BNE, 5, 6, 0,0,0, 1,1,5, 0,0), mk_stall(), "bne_load_s2");
    applyStimulus(mk_in(1, BR_BNE, 5, 6, 0,0,0, 0,0,0, 0,0), mk_exp(0,1,FWD_WB,FWD_RF,ALU_SUB), "bne_load_res");
    applyStimulus(mk_in(1, BR_BGTZ, 8, 0, 1,0,8, 0,0,0, 1,0), mk_stall(), "bgtz_ex_s1");
    applyStimulus(mk_in(1, BR_BGTZ, 8, 0, 0,0,0, 1,0,8, 1,0), mk_exp(0,0,FWD_MEM,FWD_RF,ALU_SUB_ZERO), "bgtz_ex_res");
    applyStimulus(mk_in(1, BR_BEQ, 1, 2, 0,0,0, 0,0,0, 1,0), mk_exp(0,1,FWD_RF,FWD_RF,ALU_SUB), "b2b_beq");
    applyStimulus(idle_in, idle_exp, "stats_idle");
    check_stats("stats", 32'd3, 32'd2, 32'd3);

    if (exp_q.size() != 0)
      check_val("scoreboard_leftover", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
